hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
// - Pipeline sequencer for the rv32i 5-stage core; sits beside decode_stage and the E/M/W stage registers.
// - Generates stall/flush controls (feeds flushE of the decode/execute register) and the operand-forwarding selects.
// - Holds the pipeline frozen across multi-cycle data-memory accesses (req/ack).
// - Flushes the front end for a fixed number of cycles after reset.
// PARAMETERS
// - ADW          5   register address width
// - BOOT_FLUSH   2   cycles of forced D/E flush after reset release (1..15)
// - MEM_TIMEOUT  15  max MEM_WAIT cycles before abort (1..255)
// PORTS
// - clk        in   1    clock, rising edge; the only clock
// - rst_n      in   1    reset, asynchronous, active-low
// - Rs1D/Rs2D  in   ADW  source regs of instruction in D
// - Rs1E/Rs2E  in   ADW  source regs of instruction in E
// - RdE        in   ADW  dest reg in E
// - resultsrcE in   1    1 = E holds a load
// - regwriteE  in   1    E writes the register file
// - pcsrcE     in   1    taken branch/jump resolved in E
// - RdM/RdW    in   ADW  dest regs in M and W
// - regwriteM  in   1    M writes the register file
// - regwriteW  in   1    W writes the register file
// - mem_reqM   in   1    M stage issues a data-memory access
// - mem_ackM   in   1    data memory completes the access
// - stallF/stallD/stallE/stallM  out 1  hold the stage register
// - flushD/flushE  out 1  clear the stage register (bubble)
// - fwdAE/fwdBE    out 2  00 = register file, 01 = W result, 10 = M ALU result
// - mem_err        out 1  one-cycle pulse on memory timeout
// - stall_cnt/flush_cnt  out 32  performance counters (see CONFIGURATION)
// BEHAVIOUR
// - FSM states: BOOT, RUN, MEM_WAIT. Stage outputs are combinational from state and inputs.
// - Reset (rst_n=0, asynchronous): state=BOOT, boot_cnt=BOOT_FLUSH, to_cnt=0.
//   - Outputs during reset: flushD=flushE=1, all stalls=0, fwd=00, mem_err=0, counters=0.
// - BOOT
//   - Outputs: flushD=flushE=1, stalls=0.
//   - boot_cnt decrements each cycle; at 1 -> RUN. Exactly BOOT_FLUSH flush cycles after rst_n rises.
// - RUN, evaluated in priority order:
//   1. mem_reqM & !mem_ackM: stallF/D/E/M=1, flushD/E=0. Next state MEM_WAIT, to_cnt=1.
//   2. pcsrcE: flushD=flushE=1, stalls=0. Branch wins over a load-use hit in the same cycle.
//   3. Load-use (resultsrcE & regwriteE & RdE!=0 & (RdE==Rs1D | RdE==Rs2D)): stallF=stallD=1, flushE=1, one cycle.
//   4. Otherwise all controls are 0.
//   - mem_reqM & mem_ackM in the same cycle: zero-wait access, no stall.
// - MEM_WAIT
//   - stallF/D/E/M=1, flushD/E=0. pcsrcE is ignored; E is frozen, so the branch is re-seen in RUN.
//   - mem_ackM=1: next RUN; controls that cycle are still stall.
//   - to_cnt increments each cycle. When to_cnt==MEM_TIMEOUT with no ack: mem_err=1 for that cycle, next RUN (access abandoned).
// - Forwarding, combinational in all states:
//   - fwdAE=10 if regwriteM & RdM!=0 & RdM==Rs1E.
//   - else fwdAE=01 if regwriteW & RdW!=0 & RdW==Rs1E.
//   - else fwdAE=00. fwdBE uses the same rules on Rs2E. M has priority over W.
// - x0 never triggers forwarding or load-use.
// - rst_n asserted mid-MEM_WAIT: immediate BOOT. No mem_err is issued.
// CONFIGURATION
// - Macro HAZARD_CTRL_PERF_CNT_EN.
// - Defined:
//   - stall_cnt +1 on every cycle with stallF=1.
//   - flush_cnt +1 on every cycle with flushE=1 in RUN. BOOT flushes are not counted.
//   - Both wrap at 2^32 and reset to 0.
// - Undefined: no counter flops; stall_cnt and flush_cnt are tied to 0. Ports are always present.
// TESTING
// - Reset release, BOOT_FLUSH=2 -> flushD=flushE=1 for exactly 2 cycles, then all controls 0.
// - lw x5 in E, add x6,x5,x1 in D -> 1 cycle stallF=stallD=flushE=1; next cycle fwdAE=01 (W).
// - Load-use on x5 with pcsrcE=1 in the same cycle -> flushD=flushE=1, stallF=0.
// - mem_reqM=1, ack after 3 cycles -> stallF/D/E/M=1 for 3 cycles, then 0; mem_err stays 0.
// - mem_reqM=1, no ack, MEM_TIMEOUT=15 -> mem_err=1 on the 15th wait cycle, RUN next.
// - RdM=RdW=Rs1E=3, both regwrite -> fwdAE=10; RdM=RdW=Rs1E=0 -> fwdAE=00.
// - PERF_CNT_EN: one load-use plus 3-cycle MEM_WAIT -> stall_cnt=4, flush_cnt=1.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline hazard bundle between the rv32i stages and hazard_ctrl
// Groups the register-address/control inputs from D/E/M/W and the stall, flush,
// forwarding and performance outputs. slave = hazard_ctrl side, master = pipeline side.
interface hazard_ctrl_if #(
    parameter int ADW = 5
);
    logic [ADW-1:0] Rs1D;
    logic [ADW-1:0] Rs2D;
    logic [ADW-1:0] Rs1E;
    logic [ADW-1:0] Rs2E;
    logic [ADW-1:0] RdE;
    logic           resultsrcE;
    logic           regwriteE;
    logic           pcsrcE;
    logic [ADW-1:0] RdM;
    logic [ADW-1:0] RdW;
    logic           regwriteM;
    logic           regwriteW;
    logic           mem_reqM;
    logic           mem_ackM;
    logic           stallF;
    logic           stallD;
    logic           stallE;
    logic           stallM;
    logic           flushD;
    logic           flushE;
    logic [1:0]     fwdAE;
    logic [1:0]     fwdBE;
    logic           mem_err;
    logic [31:0]    stall_cnt;
    logic [31:0]    flush_cnt;

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, resultsrcE, regwriteE, pcsrcE,
               RdM, RdW, regwriteM, regwriteW, mem_reqM, mem_ackM,
        output stallF, stallD, stallE, stallM, flushD, flushE,
               fwdAE, fwdBE, mem_err, stall_cnt, flush_cnt
    );

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, resultsrcE, regwriteE, pcsrcE,
               RdM, RdW, regwriteM, regwriteW, mem_reqM, mem_ackM,
        input  stallF, stallD, stallE, stallM, flushD, flushE,
               fwdAE, fwdBE, mem_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush/forwarding sequencer for the rv32i 5-stage pipeline
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   hz    - hazard_ctrl_if.slave: D/E/M/W register addresses and controls in,
//           stallF/D/E/M, flushD/E, fwdAE/BE, mem_err, stall_cnt/flush_cnt out
// States: BOOT (front-end flush after reset), RUN, MEM_WAIT (frozen on data memory).
// Optional feature macro HAZARD_CTRL_PERF_CNT_EN enables the stall/flush counters;
// without it both counter outputs are tied to zero.
module hazard_ctrl #(
    parameter int ADW         = 5,
    parameter int BOOT_FLUSH  = 2,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam logic [3:0] BOOT_INIT = 4'(BOOT_FLUSH);
    localparam logic [7:0] TO_LIMIT  = 8'(MEM_TIMEOUT);

    logic [ADW-1:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    assign rs1d = hz.Rs1D;
    assign rs2d = hz.Rs2D;
    assign rs1e = hz.Rs1E;
    assign rs2e = hz.Rs2E;
    assign rde  = hz.RdE;
    assign rdm  = hz.RdM;
    assign rdw  = hz.RdW;

    state_t     state_q, state_d;
    logic [3:0] boot_cnt_q, boot_cnt_d;
    logic [7:0] to_cnt_q, to_cnt_d;

    logic stall_all;
    logic stall_fd;
    logic flush_d;
    logic flush_e;
    logic mem_err;
    logic load_use;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    // A load in E whose destination is read by the instruction in D; x0 never counts.
    assign load_use = hz.resultsrcE & hz.regwriteE & (rde != '0) &
                      ((rde == rs1d) | (rde == rs2d));

    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        to_cnt_d   = to_cnt_q;
        stall_all  = 1'b0;
        stall_fd   = 1'b0;
        flush_d    = 1'b0;
        flush_e    = 1'b0;
        mem_err    = 1'b0;
        case (state_q)
            BOOT: begin
                flush_d = 1'b1;
                flush_e = 1'b1;
                if (boot_cnt_q <= 4'd1) begin
                    state_d = RUN;
                end else begin
                    boot_cnt_d = boot_cnt_q - 4'd1;
                end
            end
            RUN: begin
                if (hz.mem_reqM && !hz.mem_ackM) begin
                    stall_all = 1'b1;
                    state_d   = MEM_WAIT;
                    to_cnt_d  = 8'd1;
                end else if (hz.pcsrcE) begin
                    // Branch squashes the dependent instruction, so no stall is needed.
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                end else if (load_use) begin
                    stall_fd = 1'b1;
                    flush_e  = 1'b1;
                end
            end
            MEM_WAIT: begin
                // E is frozen here, so a pending branch is acted on after returning to RUN.
                stall_all = 1'b1;
                if (hz.mem_ackM) begin
                    state_d = RUN;
                end else if (to_cnt_q == TO_LIMIT) begin
                    mem_err = 1'b1;
                    state_d = RUN;
                end else begin
                    to_cnt_d = to_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            boot_cnt_q <= BOOT_INIT;
            to_cnt_q   <= 8'd0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    // M result is newer than W, so it takes priority; selects are held at 00 in reset.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (rst_n) begin
            if (hz.regwriteM && (rdm != '0) && (rdm == rs1e)) begin
                fwd_a = 2'b10;
            end else if (hz.regwriteW && (rdw != '0) && (rdw == rs1e)) begin
                fwd_a = 2'b01;
            end
            if (hz.regwriteM && (rdm != '0) && (rdm == rs2e)) begin
                fwd_b = 2'b10;
            end else if (hz.regwriteW && (rdw != '0) && (rdw == rs2e)) begin
                fwd_b = 2'b01;
            end
        end
    end

    assign hz.stallF  = stall_all | stall_fd;
    assign hz.stallD  = stall_all | stall_fd;
    assign hz.stallE  = stall_all;
    assign hz.stallM  = stall_all;
    assign hz.flushD  = flush_d;
    assign hz.flushE  = flush_e;
    assign hz.fwdAE   = fwd_a;
    assign hz.fwdBE   = fwd_b;
    assign hz.mem_err = mem_err;

`ifdef HAZARD_CTRL_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Boot flushes are excluded: only RUN-state flushE reflects real hazards.
    always_comb begin
        stall_cnt_d = stall_cnt_q + 32'(stall_all | stall_fd);
        flush_cnt_d = flush_cnt_q + 32'((state_q == RUN) & flush_e);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;
`else
    assign hz.stall_cnt = 32'd0;
    assign hz.flush_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;
    typedef struct packed {
        logic       rst_n;
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde;
        logic       resultsrc, regwritee, pcsrc;
        logic [4:0] rdm, rdw;
        logic       regwritem, regwritew, req, ack;
    } in_t;

    // {stallF, stallD, stallE, stallM, flushD, flushE, fwdAE, fwdBE, mem_err}
    typedef struct packed {
        logic       sf, sd, se, sm, fd, fe;
        logic [1:0] fa, fb;
        logic       err;
    } ctl_t;

    localparam ctl_t C0      = 11'b00000000000;
    localparam ctl_t C_FLUSH = 11'b00001100000;
    localparam ctl_t C_STALL = 11'b11110000000;
    localparam ctl_t C_LU    = 11'b11000100000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.ADW(5)) hz_if ();

    hazard_ctrl #(.ADW(5), .BOOT_FLUSH(2), .MEM_TIMEOUT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz_if)
    );

    ctl_t obs;
    assign obs = {hz_if.stallF, hz_if.stallD, hz_if.stallE, hz_if.stallM,
                  hz_if.flushD, hz_if.flushE, hz_if.fwdAE, hz_if.fwdBE, hz_if.mem_err};

    int    errors = 0;
    int    checks = 0;
    ctl_t  exp_q[$];
    string name_q[$];
    ctl_t  e;
    string nm;

    function automatic in_t idle();
        in_t s;
        s = '0;
        s.rst_n = 1'b1;
        return s;
    endfunction

    function automatic logic [1:0] fwd_model(input logic [4:0] rd_m, input logic wm,
                                             input logic [4:0] rd_w, input logic ww,
                                             input logic [4:0] rs);
        if (wm && rd_m != 5'd0 && rd_m == rs) return 2'b10;
        if (ww && rd_w != 5'd0 && rd_w == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic drive(input in_t s);
        rst_n            = s.rst_n;
        hz_if.Rs1D       = s.rs1d;
        hz_if.Rs2D       = s.rs2d;
        hz_if.Rs1E       = s.rs1e;
        hz_if.Rs2E       = s.rs2e;
        hz_if.RdE        = s.rde;
        hz_if.resultsrcE = s.resultsrc;
        hz_if.regwriteE  = s.regwritee;
        hz_if.pcsrcE     = s.pcsrc;
        hz_if.RdM        = s.rdm;
        hz_if.RdW        = s.rdw;
        hz_if.regwriteM  = s.regwritem;
        hz_if.regwriteW  = s.regwritew;
        hz_if.mem_reqM   = s.req;
        hz_if.mem_ackM   = s.ack;
    endtask

    task automatic test_reset();
        in_t  st[6];
        ctl_t ex[6];
        for (int i = 0; i < 6; i++) begin
            st[i] = idle();
            ex[i] = (i < 4) ? C_FLUSH : C0;
        end
        for (int i = 0; i < 2; i++) begin
            st[i].rst_n = 1'b0;
            st[i].rdm = 5'd3; st[i].rdw = 5'd3; st[i].rs1e = 5'd3;
            st[i].regwritem = 1'b1; st[i].regwritew = 1'b1; st[i].req = 1'b1;
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(st[i]);
            exp_q.push_back(ex[i]);
            name_q.push_back($sformatf("reset_%0d", i));
            #2;
            e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
            if (obs !== e) begin
                errors++; $display("FAIL %s: got %b want %b", nm, obs, e);
            end
            if (i == 1) begin
                checks++;
                if (hz_if.stall_cnt !== 32'd0) begin
                    errors++; $display("FAIL reset_stall_cnt: got %0d want 0", hz_if.stall_cnt);
                end
                checks++;
                if (hz_if.flush_cnt !== 32'd0) begin
                    errors++; $display("FAIL reset_flush_cnt: got %0d want 0", hz_if.flush_cnt);
                end
            end
        end
    endtask

    task automatic test_load_use();
        in_t  st[7];
        ctl_t ex[7];
        for (int i = 0; i < 7; i++) begin st[i] = idle(); ex[i] = C0; end
        st[0].rde = 5'd5; st[0].resultsrc = 1'b1; st[0].regwritee = 1'b1;
        st[0].rs1d = 5'd5; st[0].rs2d = 5'd1; ex[0] = C_LU;
        st[1].rs1d = 5'd5; st[1].rs2d = 5'd1; st[1].rdm = 5'd5; st[1].regwritem = 1'b1;
        st[2].rs1e = 5'd5; st[2].rs2e = 5'd1; st[2].rdw = 5'd5; st[2].regwritew = 1'b1;
        ex[2].fa = 2'b01;
        st[3].resultsrc = 1'b1; st[3].regwritee = 1'b1;
        st[4].rde = 5'd7; st[4].resultsrc = 1'b1; st[4].regwritee = 1'b1;
        st[4].rs1d = 5'd2; st[4].rs2d = 5'd7; ex[4] = C_LU;
        st[5].rde = 5'd7; st[5].regwritee = 1'b1; st[5].rs1d = 5'd7;
        st[6].rde = 5'd7; st[6].resultsrc = 1'b1; st[6].rs1d = 5'd7;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive(st[i]);
            exp_q.push_back(ex[i]);
            name_q.push_back($sformatf("load_use_%0d", i));
            #2;
            e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
            if (obs !== e) begin
                errors++; $display("FAIL %s: got %b want %b", nm, obs, e);
            end
        end
    endtask

    task automatic test_branch();
        in_t  st[3];
        ctl_t ex[3];
        for (int i = 0; i < 3; i++) st[i] = idle();
        st[0].rde = 5'd5; st[0].resultsrc = 1'b1; st[0].regwritee = 1'b1;
        st[0].rs1d = 5'd5; st[0].pcsrc = 1'b1; ex[0] = C_FLUSH;
        st[1].pcsrc = 1'b1; ex[1] = C_FLUSH;
        ex[2] = C0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(st[i]);
            exp_q.push_back(ex[i]);
            name_q.push_back($sformatf("branch_%0d", i));
            #2;
            e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
            if (obs !== e) begin
                errors++; $display("FAIL %s: got %b want %b", nm, obs, e);
            end
        end
    endtask

    task automatic test_forwarding();
        in_t  st[30];
        ctl_t ex[30];
        for (int i = 0; i < 30; i++) begin st[i] = idle(); ex[i] = C0; end
        st[0].rdm = 5'd3; st[0].rdw = 5'd3; st[0].rs1e = 5'd3;
        st[0].regwritem = 1'b1; st[0].regwritew = 1'b1; ex[0].fa = 2'b10;
        st[1].regwritem = 1'b1; st[1].regwritew = 1'b1;
        st[2].rdw = 5'd4; st[2].regwritew = 1'b1; st[2].rs2e = 5'd4; ex[2].fb = 2'b01;
        st[3].rdm = 5'd4; st[3].rdw = 5'd4; st[3].regwritew = 1'b1; st[3].rs1e = 5'd4;
        ex[3].fa = 2'b01;
        st[4].rdm = 5'd6; st[4].regwritem = 1'b1; st[4].rs1e = 5'd6; st[4].rs2e = 5'd6;
        ex[4].fa = 2'b10; ex[4].fb = 2'b10;
        st[5].rdm = 5'd6; st[5].regwritem = 1'b1; st[5].rdw = 5'd2; st[5].regwritew = 1'b1;
        st[5].rs1e = 5'd2; st[5].rs2e = 5'd6; ex[5].fa = 2'b01; ex[5].fb = 2'b10;
        for (int i = 6; i < 30; i++) begin
            st[i].rdm = 5'($urandom_range(0, 3));
            st[i].rdw = 5'($urandom_range(0, 3));
            st[i].rs1e = 5'($urandom_range(0, 3));
            st[i].rs2e = 5'($urandom_range(0, 3));
            st[i].regwritem = 1'($urandom_range(0, 1));
            st[i].regwritew = 1'($urandom_range(0, 1));
            ex[i].fa = fwd_model(st[i].rdm, st[i].regwritem, st[i].rdw, st[i].regwritew, st[i].rs1e);
            ex[i].fb = fwd_model(st[i].rdm, st[i].regwritem, st[i].rdw, st[i].regwritew, st[i].rs2e);
        end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            drive(st[i]);
            exp_q.push_back(ex[i]);
            name_q.push_back($sformatf("fwd_%0d", i));
            #2;
            e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
            if (obs !== e) begin
                errors++; $display("FAIL %s: got %b want %b", nm, obs, e);
            end
        end
    endtask

    task automatic test_mem_ack();
        in_t  st[6];
        ctl_t ex[6];
        for (int i = 0; i < 6; i++) begin st[i] = idle(); ex[i] = C0; end
        st[0].req = 1'b1; ex[0] = C_STALL;
        st[1].req = 1'b1; st[1].pcsrc = 1'b1; ex[1] = C_STALL;
        st[2].req = 1'b1; st[2].ack = 1'b1; ex[2] = C_STALL;
        st[3].pcsrc = 1'b1; ex[3] = C_FLUSH;
        st[4].req = 1'b1; st[4].ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(st[i]);
            exp_q.push_back(ex[i]);
            name_q.push_back($sformatf("mem_ack_%0d", i));
            #2;
            e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
            if (obs !== e) begin
                errors++; $display("FAIL %s: got %b want %b", nm, obs, e);
            end
        end
    endtask

    task automatic test_timeout();
        in_t  st[18];
        ctl_t ex[18];
        for (int i = 0; i < 16; i++) begin
            st[i] = idle(); st[i].req = 1'b1; ex[i] = C_STALL;
        end
        ex[15].err = 1'b1;
        st[16] = idle(); st[16].req = 1'b1; st[16].ack = 1'b1; ex[16] = C0;
        st[17] = idle(); st[17].pcsrc = 1'b1; ex[17] = C_FLUSH;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            drive(st[i]);
            exp_q.push_back(ex[i]);
            name_q.push_back($sformatf("timeout_%0d", i));
            #2;
            e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
            if (obs !== e) begin
                errors++; $display("FAIL %s: got %b want %b", nm, obs, e);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        in_t  st[21];
        ctl_t ex[21];
        for (int i = 0; i < 21; i++) begin st[i] = idle(); ex[i] = C_FLUSH; end
        for (int i = 0; i < 17; i++) st[i].req = 1'b1;
        for (int i = 2; i < 17; i++) st[i].rst_n = 1'b0;
        ex[0] = C_STALL; ex[1] = C_STALL;
        ex[19] = C0;
        st[20].req = 1'b1; st[20].ack = 1'b1; ex[20] = C0;
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            drive(st[i]);
            exp_q.push_back(ex[i]);
            name_q.push_back($sformatf("rst_wait_%0d", i));
            #2;
            e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
            if (obs !== e) begin
                errors++; $display("FAIL %s: got %b want %b", nm, obs, e);
            end
        end
    endtask

    task automatic test_perf();
        in_t  st[10];
        ctl_t ex[10];
        logic [31:0] exp_stall, exp_flush;
`ifdef HAZARD_CTRL_PERF_CNT_EN
        exp_stall = 32'd4;
        exp_flush = 32'd1;
`else
        exp_stall = 32'd0;
        exp_flush = 32'd0;
`endif
        for (int i = 0; i < 10; i++) begin st[i] = idle(); ex[i] = C0; end
        st[0].rst_n = 1'b0; ex[0] = C_FLUSH; ex[1] = C_FLUSH; ex[2] = C_FLUSH;
        st[4].rde = 5'd5; st[4].resultsrc = 1'b1; st[4].regwritee = 1'b1;
        st[4].rs1d = 5'd5; ex[4] = C_LU;
        st[6].req = 1'b1; ex[6] = C_STALL;
        st[7].req = 1'b1; ex[7] = C_STALL;
        st[8].req = 1'b1; st[8].ack = 1'b1; ex[8] = C_STALL;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(st[i]);
            exp_q.push_back(ex[i]);
            name_q.push_back($sformatf("perf_%0d", i));
            #2;
            e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
            if (obs !== e) begin
                errors++; $display("FAIL %s: got %b want %b", nm, obs, e);
            end
        end
        checks++;
        if (hz_if.stall_cnt !== exp_stall) begin
            errors++; $display("FAIL perf_stall_cnt: got %0d want %0d", hz_if.stall_cnt, exp_stall);
        end
        checks++;
        if (hz_if.flush_cnt !== exp_flush) begin
            errors++; $display("FAIL perf_flush_cnt: got %0d want %0d", hz_if.flush_cnt, exp_flush);
        end
    endtask

    initial begin
        drive('0);
        test_reset();
        test_load_use();
        test_branch();
        test_forwarding();
        test_mem_ack();
        test_timeout();
        test_reset_mid_wait();
        test_perf();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
